// File: rtl/axi_rd_arb_pkg.sv
// Shared types and AXI encodings for the two-master AXI read arbiter.
// Optional grant counters are enabled with the AXI_RD_ARB_PERF_EN macro.
package axi_rd_arb_pkg;

    // Address-channel arbitration state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_e;

    // RRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // ARBURST encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/axi_rd_arb_if.sv
// AXI read channel bundle (AR + R). The master modport is the side that
// issues addresses; the slave modport is the side that returns data.
interface axi_rd_arb_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) ();

    logic                  ARVALID;
    logic                  ARREADY;
    logic [ID_WIDTH-1:0]   ARID;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [LEN_WIDTH-1:0]  ARLEN;
    logic [2:0]            ARSIZE;
    logic [1:0]            ARBURST;

    logic                  RVALID;
    logic                  RREADY;
    logic [ID_WIDTH-1:0]   RID;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;

    modport master (
        output ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
        input  ARREADY, RVALID, RID, RDATA, RRESP, RLAST
    );

    modport slave (
        input  ARVALID, ARID, ARADDR, ARLEN, ARSIZE, ARBURST, RREADY,
        output ARREADY, RVALID, RID, RDATA, RRESP, RLAST
    );

endinterface

// File: rtl/axi_rd_arb_outst_cnt.sv
// Per-master outstanding-burst tracker: counts AR handshakes up and
// last-beat R handshakes down, saturating at MAX_OUTST and never going
// below zero. A data beat arriving with nothing outstanding sets a sticky
// error flag.
module axi_rd_arb_outst_cnt #(
    parameter int MAX_OUTST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc,
    input  logic       beat,
    input  logic       last,
    output logic [3:0] cnt,
    output logic       full,
    output logic       err
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

    logic dec;

    assign dec  = beat & last;
    assign full = (cnt == MAX_CNT);

    // Outstanding count; a simultaneous issue and completion cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            unique case ({inc, dec})
                2'b10: if (!full)      cnt <= cnt + 4'd1;
                2'b01: if (cnt != '0)  cnt <= cnt - 4'd1;
                default: ;
            endcase
        end
    end

    // Sticky flag for a data beat with no burst outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (beat && (cnt == '0)) begin
            err <= 1'b1;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter. Address requests are granted round-robin
// to a single downstream port with the master index prepended to ARID;
// read data is routed back combinationally on the top RID bit.
// Define AXI_RD_ARB_PERF_EN to add saturating per-master grant counters
// (GNT_CNT0/GNT_CNT1).
module axi_rd_arbiter
    import axi_rd_arb_pkg::*;
#(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int MAX_OUTST  = 4
) (
    input  logic          ACLK,
    input  logic          ARESETn,
    axi_rd_arb_if.slave   M0,
    axi_rd_arb_if.slave   M1,
    axi_rd_arb_if.master  S,
    output logic          ERR_UNEXP_R
`ifdef AXI_RD_ARB_PERF_EN
    ,
    output logic [15:0]   GNT_CNT0,
    output logic [15:0]   GNT_CNT1
`endif
);

    arb_state_e state, state_nxt;
    logic       rr_ptr;

    logic [3:0] outst0, outst1;
    logic       full0, full1;
    logic       err0, err1;
    logic       elig0, elig1;
    logic       ar_hs0, ar_hs1;

    logic                  ar_valid;
    logic [ID_WIDTH:0]     ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [LEN_WIDTH-1:0]  ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  m0_ready, m1_ready;

    logic                  r_sel;
    logic                  r_ready_raw;
    logic                  r_hs;
    logic                  beat0, beat1;
    logic [DATA_WIDTH-1:0] r_data;

    assign elig0  = M0.ARVALID & ~full0;
    assign elig1  = M1.ARVALID & ~full1;
    assign ar_hs0 = (state == GNT0) & S.ARREADY;
    assign ar_hs1 = (state == GNT1) & S.ARREADY;

    // State register and round-robin pointer (points away from last winner)
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state  <= IDLE;
            rr_ptr <= 1'b0;
        end else begin
            state <= state_nxt;
            if (ar_hs0) begin
                rr_ptr <= 1'b1;
            end else if (ar_hs1) begin
                rr_ptr <= 1'b0;
            end
        end
    end

    // Next-state decode and address-channel mux; grant held until handshake
    always_comb begin
        state_nxt = state;
        ar_valid  = 1'b0;
        ar_id     = '0;
        ar_addr   = '0;
        ar_len    = '0;
        ar_size   = '0;
        ar_burst  = '0;
        m0_ready  = 1'b0;
        m1_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (elig0 && elig1) begin
                    state_nxt = rr_ptr ? GNT1 : GNT0;
                end else if (elig0) begin
                    state_nxt = GNT0;
                end else if (elig1) begin
                    state_nxt = GNT1;
                end
            end
            GNT0: begin
                ar_valid = 1'b1;
                ar_id    = {1'b0, M0.ARID};
                ar_addr  = M0.ARADDR;
                ar_len   = M0.ARLEN;
                ar_size  = M0.ARSIZE;
                ar_burst = M0.ARBURST;
                m0_ready = S.ARREADY;
                if (S.ARREADY) begin
                    state_nxt = IDLE;
                end
            end
            GNT1: begin
                ar_valid = 1'b1;
                ar_id    = {1'b1, M1.ARID};
                ar_addr  = M1.ARADDR;
                ar_len   = M1.ARLEN;
                ar_size  = M1.ARSIZE;
                ar_burst = M1.ARBURST;
                m1_ready = S.ARREADY;
                if (S.ARREADY) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign S.ARVALID  = ar_valid;
    assign S.ARID     = ar_id;
    assign S.ARADDR   = ar_addr;
    assign S.ARLEN    = ar_len;
    assign S.ARSIZE   = ar_size;
    assign S.ARBURST  = ar_burst;
    assign M0.ARREADY = m0_ready;
    assign M1.ARREADY = m1_ready;

    // Read data routing on the master-select bit of RID. Only the external
    // RREADY is forced low in reset; the counters are held by their own reset.
    assign r_sel       = S.RID[ID_WIDTH];
    assign r_ready_raw = r_sel ? M1.RREADY : M0.RREADY;
    assign r_hs        = S.RVALID & r_ready_raw;
    assign beat0       = r_hs & ~r_sel;
    assign beat1       = r_hs & r_sel;
    assign r_data      = S.RDATA;

    assign S.RREADY  = ARESETn & r_ready_raw;

    assign M0.RVALID = S.RVALID & ~r_sel;
    assign M0.RID    = S.RID[ID_WIDTH-1:0];
    assign M0.RDATA  = r_data;
    assign M0.RRESP  = S.RRESP;
    assign M0.RLAST  = S.RLAST;

    assign M1.RVALID = S.RVALID & r_sel;
    assign M1.RID    = S.RID[ID_WIDTH-1:0];
    assign M1.RDATA  = r_data;
    assign M1.RRESP  = S.RRESP;
    assign M1.RLAST  = S.RLAST;

    axi_rd_arb_outst_cnt #(
        .MAX_OUTST (MAX_OUTST)
    ) u_outst0 (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .inc   (ar_hs0),
        .beat  (beat0),
        .last  (S.RLAST),
        .cnt   (outst0),
        .full  (full0),
        .err   (err0)
    );

    axi_rd_arb_outst_cnt #(
        .MAX_OUTST (MAX_OUTST)
    ) u_outst1 (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .inc   (ar_hs1),
        .beat  (beat1),
        .last  (S.RLAST),
        .cnt   (outst1),
        .full  (full1),
        .err   (err1)
    );

    // Both per-master flags are sticky, so their union is too
    assign ERR_UNEXP_R = err0 | err1;

`ifdef AXI_RD_ARB_PERF_EN
    // Saturating per-master grant counters
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            GNT_CNT0 <= '0;
            GNT_CNT1 <= '0;
        end else begin
            if (ar_hs0 && (GNT_CNT0 != '1)) begin
                GNT_CNT0 <= GNT_CNT0 + 16'd1;
            end
            if (ar_hs1 && (GNT_CNT1 != '1)) begin
                GNT_CNT1 <= GNT_CNT1 + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: arbitration order, outstanding limit,
// address-channel backpressure, read routing, unexpected-beat flag, reset.
module tb_axi_rd_arbiter;
    import axi_rd_arb_pkg::*;

    logic ACLK;
    logic ARESETn;
    logic ERR_UNEXP_R;
`ifdef AXI_RD_ARB_PERF_EN
    logic [15:0] GNT_CNT0;
    logic [15:0] GNT_CNT1;
`endif

    int checks   = 0;
    int failures = 0;

    axi_rd_arb_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) m0_if ();
    axi_rd_arb_if #(.ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) m1_if ();
    axi_rd_arb_if #(.ID_WIDTH(5), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(8)) s_if ();

    axi_rd_arbiter #(
        .ID_WIDTH   (4),
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .LEN_WIDTH  (8),
        .MAX_OUTST  (4)
    ) dut (
        .ACLK        (ACLK),
        .ARESETn     (ARESETn),
        .M0          (m0_if),
        .M1          (m1_if),
        .S           (s_if),
        .ERR_UNEXP_R (ERR_UNEXP_R)
`ifdef AXI_RD_ARB_PERF_EN
        ,
        .GNT_CNT0    (GNT_CNT0),
        .GNT_CNT1    (GNT_CNT1)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        ARESETn          = 1'b0;
        m0_if.ARVALID    = 1'b0;
        m0_if.ARID       = 4'hA;
        m0_if.ARADDR     = 32'h0000_1000;
        m0_if.ARLEN      = 8'd3;
        m0_if.ARSIZE     = 3'd2;
        m0_if.ARBURST    = BURST_INCR;
        m0_if.RREADY     = 1'b1;
        m1_if.ARVALID    = 1'b0;
        m1_if.ARID       = 4'h5;
        m1_if.ARADDR     = 32'h0000_2000;
        m1_if.ARLEN      = 8'd7;
        m1_if.ARSIZE     = 3'd2;
        m1_if.ARBURST    = BURST_WRAP;
        m1_if.RREADY     = 1'b1;
        s_if.ARREADY     = 1'b1;
        s_if.RVALID      = 1'b0;
        s_if.RID         = 5'h00;
        s_if.RDATA       = 32'h0;
        s_if.RRESP       = RESP_OKAY;
        s_if.RLAST       = 1'b0;

        // Reset state
        tick();
        check("rst_s_arvalid", 64'(s_if.ARVALID), 64'd0);
        check("rst_m0_arready", 64'(m0_if.ARREADY), 64'd0);
        check("rst_m1_arready", 64'(m1_if.ARREADY), 64'd0);
        check("rst_s_rready", 64'(s_if.RREADY), 64'd0);
        check("rst_err", 64'(ERR_UNEXP_R), 64'd0);
        tick();
        ARESETn = 1'b1;
        tick();

        // Both masters request together, pointer at M0
        m0_if.ARVALID = 1'b1;
        m1_if.ARVALID = 1'b1;
        settle();
        check("idle_s_arvalid", 64'(s_if.ARVALID), 64'd0);
        tick();
        check("rr_first_valid", 64'(s_if.ARVALID), 64'd1);
        check("rr_first_id", 64'(s_if.ARID), 64'h0A);
        check("rr_first_addr", 64'(s_if.ARADDR), 64'h1000);
        check("rr_first_len", 64'(s_if.ARLEN), 64'd3);
        check("rr_first_m0_rdy", 64'(m0_if.ARREADY), 64'd1);
        check("rr_first_m1_rdy", 64'(m1_if.ARREADY), 64'd0);
        tick();
        m0_if.ARVALID = 1'b0;
        settle();
        check("rr_gap_valid", 64'(s_if.ARVALID), 64'd0);
        tick();
        check("rr_second_id", 64'(s_if.ARID), 64'h15);
        check("rr_second_addr", 64'(s_if.ARADDR), 64'h2000);
        check("rr_second_burst", 64'(s_if.ARBURST), 64'(BURST_WRAP));
        check("rr_second_m1_rdy", 64'(m1_if.ARREADY), 64'd1);
        check("rr_second_m0_rdy", 64'(m0_if.ARREADY), 64'd0);
        tick();
        m1_if.ARVALID = 1'b0;
        settle();
        check("outst0_one", 64'(dut.u_outst0.cnt), 64'd1);
        check("outst1_one", 64'(dut.u_outst1.cnt), 64'd1);

        // Fill M0 to the outstanding limit
        m0_if.ARVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tick();
        end
        check("outst0_full", 64'(dut.u_outst0.cnt), 64'd4);
        m1_if.ARVALID = 1'b1;
        tick();
        check("full_gnt1_id", 64'(s_if.ARID), 64'h15);
        check("full_m0_rdy", 64'(m0_if.ARREADY), 64'd0);
        tick();
        check("full_gap_valid", 64'(s_if.ARVALID), 64'd0);
        // Pointer now favours M0, but M0 is full so M1 wins again
        tick();
        check("full_regrant_id", 64'(s_if.ARID), 64'h15);
        check("full_regrant_m0", 64'(m0_if.ARREADY), 64'd0);

        // Downstream backpressure in GNT1 for 3 cycles
        s_if.ARREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("bp_valid", 64'(s_if.ARVALID), 64'd1);
            check("bp_id", 64'(s_if.ARID), 64'h15);
            check("bp_addr", 64'(s_if.ARADDR), 64'h2000);
            check("bp_len", 64'(s_if.ARLEN), 64'd7);
            check("bp_m0_rdy", 64'(m0_if.ARREADY), 64'd0);
            check("bp_m1_rdy", 64'(m1_if.ARREADY), 64'd0);
            tick();
        end
        s_if.ARREADY = 1'b1;
        settle();
        check("bp_last_valid", 64'(s_if.ARVALID), 64'd1);
        check("bp_last_m1_rdy", 64'(m1_if.ARREADY), 64'd1);
        check("bp_last_m0_rdy", 64'(m0_if.ARREADY), 64'd0);
        tick();
        m1_if.ARVALID = 1'b0;
        settle();
        check("outst1_three", 64'(dut.u_outst1.cnt), 64'd3);
        tick();
        check("stall_valid", 64'(s_if.ARVALID), 64'd0);
        check("stall_m0_rdy", 64'(m0_if.ARREADY), 64'd0);

        // R beat for M1, first blocked by M1_RREADY
        s_if.RVALID  = 1'b1;
        s_if.RID     = 5'h13;
        s_if.RDATA   = 32'hCAFE_0013;
        s_if.RRESP   = RESP_SLVERR;
        s_if.RLAST   = 1'b1;
        m0_if.RREADY = 1'b1;
        m1_if.RREADY = 1'b0;
        settle();
        check("r1_blocked_rready", 64'(s_if.RREADY), 64'd0);
        m1_if.RREADY = 1'b1;
        m0_if.RREADY = 1'b0;
        settle();
        check("r1_rvalid", 64'(m1_if.RVALID), 64'd1);
        check("r1_rid", 64'(m1_if.RID), 64'h3);
        check("r1_rdata", 64'(m1_if.RDATA), 64'hCAFE_0013);
        check("r1_rresp", 64'(m1_if.RRESP), 64'(RESP_SLVERR));
        check("r1_m0_rvalid", 64'(m0_if.RVALID), 64'd0);
        check("r1_s_rready", 64'(s_if.RREADY), 64'd1);
        tick();
        s_if.RVALID = 1'b0;
        settle();
        check("outst1_dec", 64'(dut.u_outst1.cnt), 64'd2);

        // M0 beats: a non-last beat leaves the count, the last one frees a slot
        s_if.RVALID  = 1'b1;
        s_if.RID     = 5'h0A;
        s_if.RRESP   = RESP_OKAY;
        s_if.RLAST   = 1'b0;
        m0_if.RREADY = 1'b1;
        settle();
        check("r0_rvalid", 64'(m0_if.RVALID), 64'd1);
        check("r0_rid", 64'(m0_if.RID), 64'hA);
        check("r0_m1_rvalid", 64'(m1_if.RVALID), 64'd0);
        tick();
        check("r0_nonlast_cnt", 64'(dut.u_outst0.cnt), 64'd4);
        s_if.RLAST = 1'b1;
        tick();
        s_if.RVALID = 1'b0;
        settle();
        check("r0_last_cnt", 64'(dut.u_outst0.cnt), 64'd3);
        check("r0_last_valid", 64'(s_if.ARVALID), 64'd0);
        tick();
        check("unstall_valid", 64'(s_if.ARVALID), 64'd1);
        check("unstall_id", 64'(s_if.ARID), 64'h0A);

        // AR handshake and last beat for M0 in the same cycle
        s_if.RVALID = 1'b1;
        s_if.RID    = 5'h0A;
        s_if.RLAST  = 1'b1;
        tick();
        m0_if.ARVALID = 1'b0;
        s_if.RVALID   = 1'b0;
        settle();
        check("same_cycle_cnt", 64'(dut.u_outst0.cnt), 64'd3);

        // Drain M0, then send an unexpected beat
        s_if.RVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        s_if.RVALID = 1'b0;
        settle();
        check("drain_cnt", 64'(dut.u_outst0.cnt), 64'd0);
        check("drain_err", 64'(ERR_UNEXP_R), 64'd0);
        s_if.RVALID = 1'b1;
        s_if.RID    = 5'h02;
        s_if.RDATA  = 32'h1234_5678;
        settle();
        check("unexp_pass_valid", 64'(m0_if.RVALID), 64'd1);
        check("unexp_pass_data", 64'(m0_if.RDATA), 64'h1234_5678);
        tick();
        s_if.RVALID = 1'b0;
        settle();
        check("unexp_err", 64'(ERR_UNEXP_R), 64'd1);
        check("unexp_cnt", 64'(dut.u_outst0.cnt), 64'd0);
        tick();
        tick();
        check("unexp_err_sticky", 64'(ERR_UNEXP_R), 64'd1);

        // Two M0 bursts outstanding, then stall in GNT0 and reset
        m0_if.ARVALID = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            tick();
        end
        s_if.ARREADY = 1'b0;
        tick();
        check("pre_rst_valid", 64'(s_if.ARVALID), 64'd1);
        check("pre_rst_cnt", 64'(dut.u_outst0.cnt), 64'd2);
        ARESETn      = 1'b0;
        m0_if.RREADY = 1'b1;
        m1_if.RREADY = 1'b1;
        settle();
        check("in_rst_valid", 64'(s_if.ARVALID), 64'd0);
        check("in_rst_m0_rdy", 64'(m0_if.ARREADY), 64'd0);
        check("in_rst_rready", 64'(s_if.RREADY), 64'd0);
        check("in_rst_err", 64'(ERR_UNEXP_R), 64'd0);
        m0_if.ARVALID = 1'b0;
        tick();
        ARESETn = 1'b1;
        tick();
        check("post_rst_state", 64'(dut.state), 64'(IDLE));
        check("post_rst_valid", 64'(s_if.ARVALID), 64'd0);
        check("post_rst_cnt", 64'(dut.u_outst0.cnt), 64'd0);

        // Pointer was cleared by reset: M0 wins a tie again
        m0_if.ARVALID = 1'b1;
        m1_if.ARVALID = 1'b1;
        s_if.ARREADY  = 1'b1;
        tick();
        check("post_rst_rr_id", 64'(s_if.ARID), 64'h0A);
        tick();
        m0_if.ARVALID = 1'b0;
        m1_if.ARVALID = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
